// File: rtl/audio_proc_pkg.sv
// audio_proc_pkg
//   Shared definitions for the audio stream processor: output mode encodings
//   and the saturating-add / arithmetic-shift helpers used by the channel
//   datapaths. Helpers work on 32-bit signed values so they serve any
//   sample width up to 31 bits; callers sign-extend in and truncate out.
package audio_proc_pkg;

  localparam logic [1:0] MODE_MUTE = 2'b00;
  localparam logic [1:0] MODE_PASS = 2'b01;
  localparam logic [1:0] MODE_TONE = 2'b10;
  localparam logic [1:0] MODE_MIX  = 2'b11;

  // Add two sign-extended samples and clamp to the signed range of a
  // w-bit sample. The 33-bit sum cannot overflow for w < 32.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi)
      return 32'(hi);
    else if (sum < lo)
      return 32'(lo);
    else
      return 32'(sum);
  endfunction

  // Sign-preserving attenuation.
  function automatic logic signed [31:0] asr(input logic signed [31:0] x,
                                             input logic [2:0]         sh);
    return x >>> sh;
  endfunction

endpackage

// File: rtl/audio_stream_processor_if.sv
// audio_stream_processor_if
//   PCM stream between the AC'97 controller and the processing stage.
//   ready      : frame strobe, rising edge marks a new sample
//   left_in    : PCM from the codec, valid on ready rise
//   right_in   : PCM from the codec, valid on ready rise
//   left_out   : processed PCM to the codec (registered)
//   right_out  : processed PCM to the codec (registered)
//   sample_tick: one-cycle pulse when left_out/right_out update
//   master = controller side, slave = processing stage.
interface audio_stream_processor_if #(
  parameter int SAMPLE_W = 20
);
  logic                ready;
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic [SAMPLE_W-1:0] left_out;
  logic [SAMPLE_W-1:0] right_out;
  logic                sample_tick;

  modport master (
    output ready, left_in, right_in,
    input  left_out, right_out, sample_tick
  );

  modport slave (
    input  ready, left_in, right_in,
    output left_out, right_out, sample_tick
  );
endinterface

// File: rtl/audio_stream_processor_tone_gen.sv
// sample_tone_gen
//   Square-tone timing counted in samples. Each step advances the half-period
//   counter; on reaching half_period-1 (0 treated as 1) it clears and flips
//   phase. The >= compare means a half_period lowered below the current count
//   flips on the very next step instead of wrapping through the full range.
//   clock, reset_n : system clock, async active-low reset
//   step           : one-cycle sample event
//   half_period    : tone half-period in samples
//   phase          : 1 = positive half of the tone (value before this step)
//   period_done    : combinational, high on a step that flips phase high->low
module sample_tone_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                step,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                phase,
  output logic                period_done
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] limit;
  logic                at_end;

  always_comb begin
    limit       = (half_period == '0) ? '0 : half_period - PERIOD_W'(1);
    at_end      = (count >= limit);
    period_done = step & at_end & phase;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b1;
    end else if (step) begin
      if (at_end) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/audio_stream_processor.sv
// audio_stream_processor
//   Per-sample processing between the AC'97 PCM ports. On each ready rise the
//   stage registers left/right output chosen by mode (mute, passthrough, tone,
//   saturating tone+input mix), attenuated by vol_shift, and pulses
//   sample_tick. An LED chaser steps once per tone period in tone modes.
//   clock, reset_n : system clock, async active-low reset
//   pcm            : PCM stream (slave side)
//   mode           : 00 mute, 01 pass, 10 tone, 11 mix (sampled at event)
//   half_period    : tone half-period in samples (sampled at event)
//   vol_shift      : output arithmetic right shift (sampled at event)
//   LED            : one-hot chaser
module audio_stream_processor
  import audio_proc_pkg::*;
#(
  parameter int                  SAMPLE_W = 20,
  parameter int                  PERIOD_W = 16,
  parameter logic [SAMPLE_W-1:0] AMP      = 20'h08000,
  parameter int                  LED_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  audio_stream_processor_if.slave pcm,
  input  logic [1:0]           mode,
  input  logic [PERIOD_W-1:0]  half_period,
  input  logic [2:0]           vol_shift,
  output logic [LED_W-1:0]     LED
);

  localparam logic signed [31:0] AMP_S = 32'(AMP);

  logic                ready_q;
  logic                sample_evt;
  logic                phase;
  logic                period_done;
  logic signed [31:0]  l_ext;
  logic signed [31:0]  r_ext;
  logic signed [31:0]  tone;
  logic [SAMPLE_W-1:0] l_next;
  logic [SAMPLE_W-1:0] r_next;

  function automatic logic signed [31:0] chan(input logic [1:0]         m,
                                              input logic signed [31:0] x,
                                              input logic signed [31:0] t);
    case (m)
      MODE_MUTE: return '0;
      MODE_PASS: return x;
      MODE_TONE: return t;
      default:   return sat_add(x, t, SAMPLE_W);
    endcase
  endfunction

  sample_tone_gen #(
    .PERIOD_W(PERIOD_W)
  ) u_tone (
    .clock      (clock),
    .reset_n    (reset_n),
    .step       (sample_evt),
    .half_period(half_period),
    .phase      (phase),
    .period_done(period_done)
  );

  // Output uses the tone phase in effect before this event's counter update.
  always_comb begin
    sample_evt = pcm.ready & ~ready_q;
    l_ext      = 32'(signed'(pcm.left_in));
    r_ext      = 32'(signed'(pcm.right_in));
    tone       = phase ? AMP_S : -AMP_S;
    l_next     = SAMPLE_W'(asr(chan(mode, l_ext, tone), vol_shift));
    r_next     = SAMPLE_W'(asr(chan(mode, r_ext, tone), vol_shift));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_q         <= 1'b0;
      pcm.left_out    <= '0;
      pcm.right_out   <= '0;
      pcm.sample_tick <= 1'b0;
      LED             <= LED_W'(1);
    end else begin
      ready_q         <= pcm.ready;
      pcm.sample_tick <= sample_evt;
      if (sample_evt) begin
        pcm.left_out  <= l_next;
        pcm.right_out <= r_next;
      end
      if (LED == '0)
        LED <= LED_W'(1);
      else if (period_done && (mode == MODE_TONE || mode == MODE_MIX))
        LED <= {LED[LED_W-2:0], LED[LED_W-1]};
    end
  end

endmodule
